// File: rtl/dmem_if.sv
// dmem_if: core request/response and data-memory strobe bundle for dmem_access_ctrl
interface dmem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] address_d;
  logic [DATA_W-1:0] write_data;
  logic              memwrite;
  logic              memread;
  logic [DATA_W-1:0] read_data;
  modport master (
    input  req_valid, req_we, req_addr, req_wdata, read_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, address_d, write_data, memwrite, memread
  );
  modport slave (
    output req_valid, req_we, req_addr, req_wdata, read_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, address_d, write_data, memwrite, memread
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: one-at-a-time data-memory initiator, address parked between accesses;
// define DMEM_BOUNDS_CHECK_EN to reject addresses >= DEPTH with rsp_err instead of accessing memory.
module dmem_access_ctrl #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 10,
  parameter int                MEM_LAT   = 1,
  parameter logic [ADDR_W-1:0] PARK_ADDR = 32'hFFFF_FFFF
) (
  input logic   clk,
  input logic   rst,
  dmem_if.master bus
);
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_CHECK = 1'b1;
`else
  localparam bit BOUNDS_CHECK = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t            state, state_n;
  logic [3:0]        lat_cnt;
  logic              we_q, err_q, bad, accept;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  assign bad    = BOUNDS_CHECK && (bus.req_addr >= ADDR_W'(DEPTH));
  assign accept = (state == IDLE) && bus.req_valid;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // Outputs decode from state so an asynchronous reset drops the strobes at once.
  always_comb begin
    state_n = (state == IDLE)   ? (bus.req_valid ? (bad ? DONE : ACCESS) : IDLE) :
              (state == ACCESS) ? ((lat_cnt == 4'd0) ? DONE : ACCESS) : IDLE;
    bus.req_ready  = state == IDLE;
    bus.address_d  = (state == IDLE) ? PARK_ADDR : addr_q;
    bus.write_data = wdata_q;
    bus.memwrite   = (state == ACCESS) && we_q;
    bus.memread    = (state == ACCESS) && !we_q;
    bus.rsp_valid  = state == DONE;
    bus.rsp_err    = (state == DONE) && err_q;
    bus.rsp_rdata  = rdata_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lat_cnt <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      lat_cnt <= 4'(MEM_LAT - 1);
      we_q    <= bus.req_we;
      err_q   <= bad;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end else if (state == ACCESS) begin
      lat_cnt <= lat_cnt - 4'd1;
      if (lat_cnt == 4'd0 && !we_q) rdata_q <= bus.read_data;
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: runs MEM_LAT=1 and MEM_LAT=3 controllers side by side against an array-based reference.
module tb_dmem_access_ctrl;
  localparam int          DEPTH = 10;
  localparam logic [31:0] PARK  = 32'hFFFF_FFFF;
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  rv, rerr, mr, mw, rdy;
  logic [31:0] ad [2], wd [2], rr [2], rdm [2];
  logic [31:0] mem [2][DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_rd;
  int          vectors = 0, errs = 0;
  always #5 clk = ~clk;
  dmem_if b0 ();
  dmem_if b1 ();
  dmem_access_ctrl #(.MEM_LAT(1)) u0 (.clk(clk), .rst(rst), .bus(b0.master));
  dmem_access_ctrl #(.MEM_LAT(3)) u1 (.clk(clk), .rst(rst), .bus(b1.master));
  assign b0.req_valid = req_valid;
  assign b0.req_we    = req_we;
  assign b0.req_addr  = req_addr;
  assign b0.req_wdata = req_wdata;
  assign b0.read_data = rdm[0];
  assign b1.req_valid = req_valid;
  assign b1.req_we    = req_we;
  assign b1.req_addr  = req_addr;
  assign b1.req_wdata = req_wdata;
  assign b1.read_data = rdm[1];
  assign rv  = {b1.rsp_valid, b0.rsp_valid};
  assign rerr = {b1.rsp_err, b0.rsp_err};
  assign mr  = {b1.memread, b0.memread};
  assign mw  = {b1.memwrite, b0.memwrite};
  assign rdy = {b1.req_ready, b0.req_ready};
  assign ad[0] = b0.address_d;
  assign ad[1] = b1.address_d;
  assign wd[0] = b0.write_data;
  assign wd[1] = b1.write_data;
  assign rr[0] = b0.rsp_rdata;
  assign rr[1] = b1.rsp_rdata;
  function automatic logic [31:0] init_word(int a);
    case (a)
      0: return 32'd25;
      1: return 32'd17;
      2: return 32'd20;
      3: return 32'd78;
      7: return 32'd39;
      8: return 32'd113;
      default: return 32'(a * 1000 + 7);
    endcase
  endfunction
  function automatic int lat_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction
  // Memory model: combinational read, write on each clock with memwrite high, out-of-range ignored.
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < DEPTH; a++)
        if (rst) mem[i][a] <= init_word(a);
        else if (mw[i] && ad[i] == 32'(a)) mem[i][a] <= wd[i];
  always_comb
    for (int i = 0; i < 2; i++) begin
      rdm[i] = '0;
      for (int a = 0; a < DEPTH; a++)
        if (ad[i] == 32'(a)) rdm[i] = mem[i][a];
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s ready u%0d", tag, i), 32'(rdy[i]), 32'd1);
      chk($sformatf("%s rsp_valid u%0d", tag, i), 32'(rv[i]), 32'd0);
      chk($sformatf("%s rsp_err u%0d", tag, i), 32'(rerr[i]), 32'd0);
      chk($sformatf("%s memread u%0d", tag, i), 32'(mr[i]), 32'd0);
      chk($sformatf("%s memwrite u%0d", tag, i), 32'(mw[i]), 32'd0);
      chk($sformatf("%s address u%0d", tag, i), ad[i], PARK);
      chk($sformatf("%s write_data u%0d", tag, i), wd[i], 32'd0);
      chk($sformatf("%s rsp_rdata u%0d", tag, i), rr[i], 32'd0);
    end
  endtask
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    bit          bad;
    int          krsp [2], rc [2], wc [2];
    bit          aok [2], rok [2], dup [2];
    logic [31:0] got_rd [2], got_err [2];
    bad = CHK && (addr >= 32'(DEPTH));
    for (int i = 0; i < 2; i++) begin
      krsp[i] = 0; rc[i] = 0; wc[i] = 0; aok[i] = 1; rok[i] = 1; dup[i] = 0;
      got_rd[i] = 'x; got_err[i] = 'x;
      chk($sformatf("%s idle ready u%0d", tag, i), 32'(rdy[i]), 32'd1);
      chk($sformatf("%s parked u%0d", tag, i), ad[i], PARK);
    end
    if (!bad && !we) last_rd = (addr < 32'(DEPTH)) ? ref_mem[addr[3:0]] : 32'd0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    step();
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int k = 1; k <= 20; k++) begin
      for (int i = 0; i < 2; i++)
        if (krsp[i] == 0) begin
          if (mr[i]) rc[i]++;
          if (mw[i]) wc[i]++;
          if ((mr[i] || mw[i]) && (ad[i] !== addr || (mw[i] && wd[i] !== wdata))) aok[i] = 0;
          if (rdy[i]) rok[i] = 0;
          if (rv[i]) begin
            krsp[i] = k; got_rd[i] = rr[i]; got_err[i] = 32'(rerr[i]);
          end
        end else if (rv[i]) dup[i] = 1;
      if (krsp[0] != 0 && krsp[1] != 0) break;
      step();
    end
    step();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s latency u%0d", tag, i), 32'(krsp[i]), bad ? 32'd1 : 32'(lat_of(i) + 1));
      chk($sformatf("%s memread cycles u%0d", tag, i), 32'(rc[i]), (bad || we) ? 32'd0 : 32'(lat_of(i)));
      chk($sformatf("%s memwrite cycles u%0d", tag, i), 32'(wc[i]), (bad || !we) ? 32'd0 : 32'(lat_of(i)));
      chk($sformatf("%s addr/wdata held u%0d", tag, i), 32'(aok[i]), 32'd1);
      chk($sformatf("%s ready low u%0d", tag, i), 32'(rok[i]), 32'd1);
      chk($sformatf("%s single pulse u%0d", tag, i), 32'(dup[i]), 32'd0);
      chk($sformatf("%s pulse ended u%0d", tag, i), 32'(rv[i]), 32'd0);
      chk($sformatf("%s rsp_err u%0d", tag, i), got_err[i], 32'(bad));
      chk($sformatf("%s rsp_rdata u%0d", tag, i), got_rd[i], last_rd);
    end
    if (!bad && we && addr < 32'(DEPTH)) ref_mem[addr[3:0]] = wdata;
  endtask
  initial begin
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = init_word(a);
    last_rd = '0;
    step();
    step();
    reset_vals("reset");
    rst = 1'b0;
    step();
    access(1'b0, 32'd3, 32'd0, "load3");
    access(1'b1, 32'd5, 32'd99, "store5");
    access(1'b0, 32'd5, 32'd0, "load5");
    access(1'b0, 32'd7, 32'd0, "load7a");
    access(1'b0, 32'd7, 32'd0, "load7b");
    access(1'b0, 32'd12, 32'd0, "load12");
    access(1'b0, 32'd8, 32'd0, "load8");
    access(1'b1, 32'd12, 32'hDEAD, "store12");
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd0; req_wdata = 32'h1234;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) chk($sformatf("midrst memwrite before u%0d", i), 32'(mw[i]), 32'd1);
    rst = 1'b1;
    #1;
    reset_vals("midrst");
    step();
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = init_word(a);
    last_rd = '0;
    for (int c = 0; c < 5; c++) begin
      chk("midrst no rsp", 32'(rv), 32'd0);
      step();
    end
    access(1'b0, 32'd0, 32'd0, "load0 after rst");
    repeat (40) access(1'($urandom), 32'($urandom_range(0, DEPTH + 3)), $urandom, "rand");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Clocked initiator for the word-addressed data memory. Accepts one load or store at a time from the core over a valid/ready handshake and drives the memory's address, write-data and read/write strobes. Holds the access for a programmable number of cycles, captures read data, and returns a one-cycle response pulse. The memory responds only when its address changes, so between accesses this block parks the address on a fixed idle value. Back-to-back accesses to the same word are therefore always seen by the memory.

## Interface
Parameters:
- DATA_W, 32, data word width
- ADDR_W, 32, word-address width
- DEPTH, 10, number of implemented memory words; valid addresses are 0..DEPTH-1
- MEM_LAT, 1, cycles the address/strobe are held before read data is sampled; legal range 1..15
- PARK_ADDR, 32'hFFFF_FFFF, address driven while idle; must be >= DEPTH

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  core request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  load result; holds last load value otherwise
- rsp_err  out  1  qualified by rsp_valid; address out of range
- address_d  out  ADDR_W  to memory address
- write_data  out  DATA_W  to memory write data
- memwrite  out  1  memory write strobe
- memread  out  1  memory read strobe
- read_data  in  DATA_W  from memory read data

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - req_ready=1; address_d=PARK_ADDR; memread=memwrite=0.
  - On req_valid, latch we/addr/wdata.
  - In-range request, or any request when the macro is off: go to ACCESS and load lat_cnt=MEM_LAT-1.
  - Out-of-range request with the macro on: go directly to DONE with err=1; no strobe is asserted.
- ACCESS:
  - address_d=latched addr; write_data=latched wdata; memwrite=we; memread=~we.
  - Decrement lat_cnt each cycle. When lat_cnt==0, go to DONE. On a load, rsp_rdata<=read_data at that same edge.
- DONE:
  - rsp_valid=1 for exactly one cycle; rsp_err=err.
  - Strobes are 0; address_d stays at the latched addr, so the address never moves while a strobe is high.
  - Next state is IDLE, which re-parks the address.
- Request inputs are ignored outside IDLE; the core must hold them only until accepted.
- There is no response backpressure; the core must take rsp_valid when it pulses.
- Stores leave rsp_rdata unchanged.
- Error responses leave rsp_rdata unchanged and never touch memory.

## Timing
- Reset values:
  - state=IDLE, req_ready=1
  - rsp_valid=0, rsp_err=0, rsp_rdata=0
  - address_d=PARK_ADDR, write_data=0, memread=0, memwrite=0
- Reset asserted mid-ACCESS: strobes drop immediately (asynchronous), the access is abandoned and no rsp_valid is produced.
- Latency, accept edge to rsp_valid high:
  - memory access: MEM_LAT+1 cycles
  - error response: 1 cycle
- Throughput: one access every MEM_LAT+2 cycles. req_ready is low from the cycle after accept through DONE.
- The address is parked for at least one cycle between any two accesses.
- lat_cnt is 4 bits; MEM_LAT=1 gives exactly one ACCESS cycle.

## Configuration
- DMEM_BOUNDS_CHECK_EN defined:
  - Addresses >= DEPTH are rejected with rsp_err=1 after 1 cycle.
  - memread and memwrite stay 0 for rejected requests.
- DMEM_BOUNDS_CHECK_EN undefined:
  - No comparison is made; every request goes through ACCESS.
  - rsp_err is tied to 0.

## Test plan
- Reset, then load addr 3 with memory preloaded 25,17,20,78,... and MEM_LAT=1 -> req_ready drops; memread=1, address_d=3 for 1 cycle; rsp_valid 2 cycles after accept with rsp_rdata=78, rsp_err=0.
- Store addr 5 data 99, then load addr 5 -> store asserts memwrite for 1 cycle with write_data=99; load returns rsp_rdata=99.
- Two consecutive loads of addr 7 -> address_d goes 7, PARK_ADDR, 7 between them; both responses return 39.
- Load addr 12, macro defined -> rsp_valid 1 cycle after accept with rsp_err=1; memread never high; rsp_rdata keeps its previous value.
- MEM_LAT=3, load addr 8 -> memread high for exactly 3 cycles; rsp_rdata=113 at accept+4.
- Assert rst during the ACCESS of a store to addr 0 -> memwrite drops in the same cycle; all outputs return to reset values; no rsp_valid pulse.
